// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory wait handling, timeout fault and sticky halt/fault states.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ENABLE_UPPER   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       jump,
    output logic       jump_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEMORY = 3'd3,
                           S_WRITEBACK = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_HALT = 7'b1111111, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111;

    // Width guard keeps the counter at least 1 bit when the timeout is disabled.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);

    logic [2:0]    nxt;
    logic [6:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          legal;
    logic          timeout;

    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
            OP_LUI, OP_AUIPC: legal = ENABLE_UPPER;
            default: legal = 1'b0;
        endcase
    end

    // Fault on the cycle whose low mem_ready would bring the count to the limit.
    assign timeout = (TIMEOUT_CYCLES != 0) && !mem_ready && (int'(wait_cnt) + 1 >= TIMEOUT_CYCLES);

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    nxt = S_DECODE;
                else if (timeout) nxt = S_FAULT;
            end
            S_DECODE: begin
                if (opcode == OP_HALT) nxt = S_HALT;
                else if (legal)        nxt = S_EXECUTE;
                else                   nxt = S_FAULT;
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_R, OP_I, OP_LUI, OP_AUIPC:  nxt = S_WRITEBACK;
                    OP_LOAD, OP_STORE:             nxt = S_MEMORY;
                    OP_BRANCH, OP_JAL, OP_JALR:    nxt = S_FETCH;
                    default:                       nxt = S_FAULT;
                endcase
            end
            S_MEMORY: begin
                if (mem_ready)    nxt = (op_q == OP_LOAD) ? S_WRITEBACK : S_FETCH;
                else if (timeout) nxt = S_FAULT;
            end
            S_WRITEBACK: nxt = S_FETCH;
            S_HALT:      nxt = S_HALT;
            default:     nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE) op_q <= opcode;
            if (nxt != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEMORY) && !mem_ready && wait_cnt != T_MAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Strobes are gated by rst_n so reset silences them without waiting for a clock.
    always_comb begin
        pc_write = 1'b0; ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; mem_to_reg = 1'b0; branch = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        alu_src_a = 2'b00; alu_src_b = 2'b00; alu_op = 2'b00; halted = 1'b0; fault = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b10;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_EXECUTE: begin
                    case (op_q)
                        OP_R:      begin alu_src_a = 2'b01; alu_op = 2'b10; end
                        OP_I:      begin alu_src_a = 2'b01; alu_src_b = 2'b01; alu_op = 2'b10; end
                        OP_LOAD, OP_STORE: begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
                        OP_BRANCH: begin alu_src_a = 2'b01; alu_op = 2'b01; branch = 1'b1; end
                        OP_JAL:    begin jump = 1'b1; pc_write = 1'b1; reg_write = 1'b1; end
                        OP_JALR: begin
                            jump = 1'b1; pc_write = 1'b1; reg_write = 1'b1; jump_reg = 1'b1;
                            alu_src_a = 2'b01; alu_src_b = 2'b01;
                        end
                        OP_LUI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
                        OP_AUIPC:  alu_src_b = 2'b01;
                        default: ;
                    endcase
                end
                S_MEMORY: begin
                    if (op_q == OP_LOAD) mem_read = 1'b1;
                    else                 mem_write = 1'b1;
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LOAD);
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus randomized instruction
// streams checked against a per-instruction phase model.
module tb_multicycle_controller;
    logic       clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, jump_reg;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       halted, fault;
    logic [2:0] state;
    logic       u_pcw, u_irw, u_mr, u_mw, u_rw, u_mtr, u_br, u_j, u_jr, u_h, u_f;
    logic [1:0] u_a, u_b, u_o;
    logic [2:0] u_state;

    int checks = 0, errors = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, HLT = 7'b1111111,
                           LUI = 7'b0110111, AUIPC = 7'b0010111;

    multicycle_controller #(.TIMEOUT_CYCLES(4), .ENABLE_UPPER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
        .jump_reg(jump_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .halted(halted), .fault(fault), .state(state));

    multicycle_controller #(.TIMEOUT_CYCLES(4), .ENABLE_UPPER(1'b0)) dut_nu (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(u_pcw), .ir_write(u_irw), .mem_read(u_mr), .mem_write(u_mw),
        .reg_write(u_rw), .mem_to_reg(u_mtr), .branch(u_br), .jump(u_j),
        .jump_reg(u_jr), .alu_src_a(u_a), .alu_src_b(u_b), .alu_op(u_o),
        .halted(u_h), .fault(u_f), .state(u_state));

    always #5 clk = ~clk;

    wire [16:0] outs = {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, branch,
                        jump, jump_reg, alu_src_a, alu_src_b, alu_op, halted, fault};

    // Expected strobe vector for a state, the instruction being executed and mem_ready.
    function automatic logic [16:0] exp_out(input logic [2:0] st, input logic [6:0] op, input logic rdy);
        logic pcw, irw, mr, mw, rw, mtr, br, j, jr, h, f;
        logic [1:0] a, b, o;
        {pcw, irw, mr, mw, rw, mtr, br, j, jr, h, f} = '0;
        a = 2'b00; b = 2'b00; o = 2'b00;
        case (st)
            3'd0: begin mr = 1; b = 2'b10; pcw = rdy; irw = rdy; end
            3'd2: case (op)
                R:     begin a = 2'b01; o = 2'b10; end
                I:     begin a = 2'b01; b = 2'b01; o = 2'b10; end
                LD, ST: begin a = 2'b01; b = 2'b01; end
                BR:    begin a = 2'b01; o = 2'b01; br = 1; end
                JAL:   begin j = 1; pcw = 1; rw = 1; end
                JALR:  begin j = 1; pcw = 1; rw = 1; jr = 1; a = 2'b01; b = 2'b01; end
                LUI:   begin a = 2'b10; b = 2'b01; end
                AUIPC: b = 2'b01;
                default: ;
            endcase
            3'd3: if (op == LD) mr = 1; else mw = 1;
            3'd4: begin rw = 1; mtr = (op == LD); end
            3'd5: h = 1;
            3'd6: f = 1;
            default: ;
        endcase
        return {pcw, irw, mr, mw, rw, mtr, br, j, jr, a, b, o, h, f};
    endfunction

    // One cycle: inputs applied at the falling edge, outputs observed 1 ns later.
    task automatic tick(input logic rdy, input logic [6:0] opc);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = rdy; opcode = opc;
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = R;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (outs !== 17'h0) begin errors++; $display("FAIL reset_outs got %h want 0", outs); end
        @(posedge clk); #1;
        checks++; if (state !== 3'd0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL reset_hold state %0d mem_read %b want 0 0", state, mem_read); end
    endtask

    task automatic test_rtype();
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        hold_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, R);
            checks++; if (state !== exp_st[i] || reg_write !== (exp_st[i] == 3'd4)) begin
                errors++; $display("FAIL rtype_step%0d state %0d rw %b want %0d %b", i, state, reg_write,
                                   exp_st[i], exp_st[i] == 3'd4); end
            if (exp_st[i] == 3'd2) begin
                checks++; if (alu_op !== 2'b10) begin errors++; $display("FAIL rtype_aluop got %b want 10", alu_op); end
            end
        end
    endtask

    task automatic test_load_wait();
        hold_reset();
        tick(1'b1, LD); tick(1'b1, LD); tick(1'b1, 7'($urandom));
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL load_exec got %0d want 2", state); end
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, 7'($urandom));
            checks++; if (state !== 3'd3 || mem_read !== 1'b1) begin
                errors++; $display("FAIL load_mem%0d state %0d mem_read %b want 3 1", i, state, mem_read); end
        end
        tick(1'b1, 7'($urandom));
        checks++; if (state !== 3'd4 || mem_to_reg !== 1'b1 || reg_write !== 1'b1) begin
            errors++; $display("FAIL load_wb state %0d mtr %b rw %b want 4 1 1", state, mem_to_reg, reg_write); end
        tick(1'b0, R);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL load_done got %0d want 0", state); end
    endtask

    task automatic test_timeout();
        hold_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, R);
            checks++; if (state !== 3'd0 || fault !== 1'b0) begin
                errors++; $display("FAIL timeout_wait%0d state %0d fault %b want 0 0", i, state, fault); end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom), 7'($urandom));
            checks++; if (state !== 3'd6 || outs !== 17'h1) begin
                errors++; $display("FAIL timeout_fault%0d state %0d outs %h want 6 00001", i, state, outs); end
        end
        hold_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, R);
        tick(1'b1, R);
        checks++; if (state !== 3'd0 || ir_write !== 1'b1) begin
            errors++; $display("FAIL timeout_edge state %0d ir_write %b want 0 1", state, ir_write); end
        tick(1'b1, R);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL timeout_edge_decode got %0d want 1", state); end
    endtask

    task automatic test_halt();
        int bad = 0;
        hold_reset();
        tick(1'b1, R); tick(1'($urandom), HLT);
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom), 7'($urandom));
            if (state !== 3'd5 || outs !== 17'h2) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_hold bad_cycles %0d want 0 (state %0d)", bad, state); end
        rst_n = 1'b0; #1;
        checks++; if (state !== 3'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_reset state %0d halted %b want 0 0", state, halted); end
        tick(1'b1, R);
        checks++; if (state !== 3'd0 || mem_read !== 1'b1) begin
            errors++; $display("FAIL halt_refetch state %0d mem_read %b want 0 1", state, mem_read); end
    endtask

    task automatic test_upper();
        hold_reset();
        tick(1'b1, LUI); tick(1'b1, LUI); tick(1'b1, 7'($urandom));
        checks++; if (state !== 3'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin
            errors++; $display("FAIL upper_exec state %0d a %b b %b want 2 10 01", state, alu_src_a, alu_src_b); end
        checks++; if (u_state !== 3'd6 || u_f !== 1'b1) begin
            errors++; $display("FAIL upper_disabled state %0d fault %b want 6 1", u_state, u_f); end
        tick(1'b1, 7'($urandom));
        checks++; if (state !== 3'd4 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin
            errors++; $display("FAIL upper_wb state %0d rw %b mtr %b want 4 1 0", state, reg_write, mem_to_reg); end
    endtask

    task automatic test_store_reset();
        hold_reset();
        tick(1'b1, ST); tick(1'b1, ST); tick(1'b1, ST); tick(1'b0, 7'($urandom));
        checks++; if (state !== 3'd3 || mem_write !== 1'b1) begin
            errors++; $display("FAIL store_mem state %0d mem_write %b want 3 1", state, mem_write); end
        #1 rst_n = 1'b0; #1;
        checks++; if (state !== 3'd0 || mem_write !== 1'b0 || outs !== 17'h0) begin
            errors++; $display("FAIL store_reset state %0d outs %h want 0 0", state, outs); end
        tick(1'b1, R);
        checks++; if (state !== 3'd0 || ir_write !== 1'b1) begin
            errors++; $display("FAIL store_refetch state %0d ir_write %b want 0 1", state, ir_write); end
    endtask

    typedef struct { logic [2:0] st; logic rdy; logic [6:0] opc; logic [6:0] op; } step_t;

    task automatic test_random();
        logic [6:0] pool [10] = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC, R};
        step_t q[$];
        step_t s;
        logic [6:0] op;
        int nf, nm;
        hold_reset();
        for (int n = 0; n < 40; n++) begin
            op = pool[$urandom_range(0, 9)];
            nf = $urandom_range(0, 3);
            nm = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) q.push_back('{3'd0, 1'b0, 7'($urandom), op});
            q.push_back('{3'd0, 1'b1, 7'($urandom), op});
            q.push_back('{3'd1, 1'($urandom), op, op});
            q.push_back('{3'd2, 1'($urandom), 7'($urandom), op});
            if (op == LD || op == ST) begin
                for (int k = 0; k < nm; k++) q.push_back('{3'd3, 1'b0, 7'($urandom), op});
                q.push_back('{3'd3, 1'b1, 7'($urandom), op});
            end
            if (op != ST && op != BR && op != JAL && op != JALR)
                q.push_back('{3'd4, 1'($urandom), 7'($urandom), op});
        end
        while (q.size() > 0) begin
            s = q.pop_front();
            tick(s.rdy, s.opc);
            checks++; if (state !== s.st || outs !== exp_out(s.st, s.op, s.rdy)) begin
                errors++; $display("FAIL random op %b state %0d outs %h want %0d %h", s.op, state, outs,
                                   s.st, exp_out(s.st, s.op, s.rdy)); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_timeout();
        test_halt();
        test_upper();
        test_store_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
